// File: rtl/selecionar_ativo.sv
// Locates the active node holding the global minimum criterion, hands its index/address
// downstream over a valid/release handshake, then pulses a one-hot grant back to the array.
module selecionar_ativo #(
  parameter int unsigned NUM_NA         = 8,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned CRITERIO_WIDTH = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ca_pronto_in,
  input  logic [CRITERIO_WIDTH-1:0]        ca_criterio_geral_in,
  input  logic [NUM_NA-1:0]                na_ativo_in,
  input  logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in,
  input  logic [NUM_NA*ADDR_WIDTH-1:0]     na_endereco_in,
  input  logic                             sa_liberar_in,
  output logic                             sa_valido_o,
  output logic [$clog2(NUM_NA)-1:0]        sa_indice_o,
  output logic [ADDR_WIDTH-1:0]            sa_endereco_o,
  output logic [NUM_NA-1:0]                sa_grant_o,
  output logic                             sa_vazio_o,
  output logic                             sa_ocupado_o
);

  localparam int unsigned COUNT_WIDTH = $clog2(NUM_NA);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    VALID = 2'd2,
    GRANT = 2'd3
  } state_t;

  state_t                    state_q;
  logic [COUNT_WIDTH-1:0]    count_q;
  logic [CRITERIO_WIDTH-1:0] crit_q;
  logic                      valido_q;
  logic [COUNT_WIDTH-1:0]    indice_q;
  logic [ADDR_WIDTH-1:0]     endereco_q;
  logic [NUM_NA-1:0]         grant_q;
  logic                      vazio_q;
  logic                      ocupado_q;

  logic [CRITERIO_WIDTH-1:0] crit_arr [NUM_NA];
  logic [ADDR_WIDTH-1:0]     addr_arr [NUM_NA];
  logic [NUM_NA-1:0]         grant_d;
  logic                      match_c;
  logic                      last_c;

  // Unpack the flat node buses into per-slot views
  for (genvar g = 0; g < NUM_NA; g++) begin : g_unpack
    assign crit_arr[g] = na_criterio_in[CRITERIO_WIDTH*g +: CRITERIO_WIDTH];
    assign addr_arr[g] = na_endereco_in[ADDR_WIDTH*g +: ADDR_WIDTH];
  end

  assign match_c = na_ativo_in[count_q] && (crit_arr[count_q] == crit_q);
  assign last_c  = (count_q == COUNT_WIDTH'(NUM_NA - 1));

  always_comb begin
    grant_d           = '0;
    grant_d[indice_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      crit_q     <= '0;
      valido_q   <= 1'b0;
      indice_q   <= '0;
      endereco_q <= '0;
      grant_q    <= '0;
      vazio_q    <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      vazio_q <= 1'b0;
      grant_q <= '0;
      case (state_q)
        IDLE: begin
          if (ca_pronto_in) begin
            crit_q <= ca_criterio_geral_in;
            if (na_ativo_in == '0) begin
              vazio_q <= 1'b1;
            end else begin
              state_q   <= SCAN;
              count_q   <= '0;
              ocupado_q <= 1'b1;
            end
          end
        end
        SCAN: begin
          // Ascending scan makes ties resolve to the lowest index
          if (match_c) begin
            indice_q   <= count_q;
            endereco_q <= addr_arr[count_q];
            valido_q   <= 1'b1;
            state_q    <= VALID;
          end else if (last_c) begin
            vazio_q   <= 1'b1;
            ocupado_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            count_q <= count_q + COUNT_WIDTH'(1);
          end
        end
        VALID: begin
          if (sa_liberar_in) begin
            valido_q <= 1'b0;
            grant_q  <= grant_d;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          ocupado_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          ocupado_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign sa_valido_o   = valido_q;
  assign sa_indice_o   = indice_q;
  assign sa_endereco_o = endereco_q;
  assign sa_grant_o    = grant_q;
  assign sa_vazio_o    = vazio_q;
  assign sa_ocupado_o  = ocupado_q;

endmodule

// File: tb/tb_selecionar_ativo.sv
// Bench for selecionar_ativo: hand-written vector table, reset corner sequences, and
// randomized transactions checked against a lowest-matching-slot reference model.
module tb_selecionar_ativo;

  localparam int N  = 8;
  localparam int AW = 8;
  localparam int CW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            ca_pronto_in;
  logic [CW-1:0]   ca_criterio_geral_in;
  logic [N-1:0]    na_ativo_in;
  logic [N*CW-1:0] na_criterio_in;
  logic [N*AW-1:0] na_endereco_in;
  logic            sa_liberar_in;
  logic            sa_valido_o;
  logic [2:0]      sa_indice_o;
  logic [AW-1:0]   sa_endereco_o;
  logic [N-1:0]    sa_grant_o;
  logic            sa_vazio_o;
  logic            sa_ocupado_o;

  int checks   = 0;
  int failures = 0;

  selecionar_ativo #(.NUM_NA(N), .ADDR_WIDTH(AW), .CRITERIO_WIDTH(CW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ca_pronto_in         (ca_pronto_in),
    .ca_criterio_geral_in (ca_criterio_geral_in),
    .na_ativo_in          (na_ativo_in),
    .na_criterio_in       (na_criterio_in),
    .na_endereco_in       (na_endereco_in),
    .sa_liberar_in        (sa_liberar_in),
    .sa_valido_o          (sa_valido_o),
    .sa_indice_o          (sa_indice_o),
    .sa_endereco_o        (sa_endereco_o),
    .sa_grant_o           (sa_grant_o),
    .sa_vazio_o           (sa_vazio_o),
    .sa_ocupado_o         (sa_ocupado_o)
  );

  always #5 clk = ~clk;

  // Expected outcome kinds
  localparam int K_EMPTY = 0;
  localparam int K_MISS  = 1;
  localparam int K_HIT   = 2;

  typedef struct {
    logic [N-1:0]    act;
    logic [N*CW-1:0] crits;
    logic [CW-1:0]   tgt;
    int              lib_wait;
    bit              pulse_pronto;
    int              exp_kind;
    int              exp_idx;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".valido"},   64'(sa_valido_o),   64'd0);
    chk({nm, ".indice"},   64'(sa_indice_o),   64'd0);
    chk({nm, ".endereco"}, 64'(sa_endereco_o), 64'd0);
    chk({nm, ".grant"},    64'(sa_grant_o),    64'd0);
    chk({nm, ".vazio"},    64'(sa_vazio_o),    64'd0);
    chk({nm, ".ocupado"},  64'(sa_ocupado_o),  64'd0);
  endtask

  // Reference model: first active slot (ascending) whose criterion equals the target
  task automatic model(input logic [N-1:0] act, input logic [N*CW-1:0] crits,
                       input logic [CW-1:0] tgt, output int kind, output int idx);
    idx  = -1;
    kind = K_MISS;
    if (act == '0) kind = K_EMPTY;
    else
      for (int i = N - 1; i >= 0; i--)
        if (act[i] && crits[CW*i +: CW] == tgt) idx = i;
    if (idx >= 0) kind = K_HIT;
  endtask

  // Launch one pronto pulse and follow the whole transaction cycle by cycle
  task automatic do_txn(input string nm, input logic [N-1:0] act, input logic [N*CW-1:0] crits,
                        input logic [N*AW-1:0] addrs, input logic [CW-1:0] tgt,
                        input int lib_wait, input bit pulse, input int kind, input int idx);
    logic [AW-1:0] eaddr;
    logic [N-1:0]  egrant;
    na_ativo_in          = act;
    na_criterio_in       = crits;
    na_endereco_in       = addrs;
    ca_criterio_geral_in = tgt;
    ca_pronto_in         = 1'b1;
    step();
    ca_pronto_in         = 1'b0;
    ca_criterio_geral_in = ~tgt;
    if (kind == K_EMPTY) begin
      chk({nm, ".empty_vazio"},   64'(sa_vazio_o),   64'd1);
      chk({nm, ".empty_ocupado"}, 64'(sa_ocupado_o), 64'd0);
      step();
      chk({nm, ".empty_vazio_end"}, 64'(sa_vazio_o),   64'd0);
      chk({nm, ".empty_ocupado2"},  64'(sa_ocupado_o), 64'd0);
    end else if (kind == K_MISS) begin
      for (int n = 1; n <= N; n++) begin
        chk($sformatf("%s.miss_ocupado_t%0d", nm, n), 64'(sa_ocupado_o), 64'd1);
        chk($sformatf("%s.miss_vazio_t%0d", nm, n),   64'(sa_vazio_o),   64'd0);
        step();
      end
      chk({nm, ".miss_vazio"},   64'(sa_vazio_o),   64'd1);
      chk({nm, ".miss_ocupado"}, 64'(sa_ocupado_o), 64'd0);
      step();
      chk({nm, ".miss_vazio_end"}, 64'(sa_vazio_o), 64'd0);
    end else begin
      eaddr       = addrs[AW*idx +: AW];
      egrant      = '0;
      egrant[idx] = 1'b1;
      for (int n = 1; n <= idx + 1; n++) begin
        chk($sformatf("%s.scan_valido_t%0d", nm, n),  64'(sa_valido_o),  64'd0);
        chk($sformatf("%s.scan_ocupado_t%0d", nm, n), 64'(sa_ocupado_o), 64'd1);
        sa_liberar_in = 1'b1;  // early release must be ignored
        step();
      end
      sa_liberar_in = 1'b0;
      chk({nm, ".valido"},   64'(sa_valido_o),   64'd1);
      chk({nm, ".indice"},   64'(sa_indice_o),   64'(idx));
      chk({nm, ".endereco"}, 64'(sa_endereco_o), 64'(eaddr));
      chk({nm, ".grant0"},   64'(sa_grant_o),    64'd0);
      for (int w = 0; w < lib_wait; w++) begin
        if (pulse && w == 1) begin
          ca_pronto_in         = 1'b1;
          ca_criterio_geral_in = tgt;
        end
        step();
        ca_pronto_in = 1'b0;
        chk($sformatf("%s.hold_valido_w%0d", nm, w),   64'(sa_valido_o),   64'd1);
        chk($sformatf("%s.hold_indice_w%0d", nm, w),   64'(sa_indice_o),   64'(idx));
        chk($sformatf("%s.hold_endereco_w%0d", nm, w), 64'(sa_endereco_o), 64'(eaddr));
        chk($sformatf("%s.hold_grant_w%0d", nm, w),    64'(sa_grant_o),    64'd0);
      end
      sa_liberar_in = 1'b1;
      step();
      sa_liberar_in = 1'b0;
      chk({nm, ".grant"},         64'(sa_grant_o),   64'(egrant));
      chk({nm, ".grant_valido"},  64'(sa_valido_o),  64'd0);
      chk({nm, ".grant_ocupado"}, 64'(sa_ocupado_o), 64'd1);
      step();
      chk({nm, ".post_grant"},   64'(sa_grant_o),   64'd0);
      chk({nm, ".post_ocupado"}, 64'(sa_ocupado_o), 64'd0);
      step();
      chk({nm, ".idle_valido"},  64'(sa_valido_o),  64'd0);
      chk({nm, ".idle_ocupado"}, 64'(sa_ocupado_o), 64'd0);
    end
    step();
  endtask

  vec_t            vecs [7];
  logic [N*AW-1:0] base_addrs;

  initial begin
    logic [N-1:0]    ra;
    logic [N*CW-1:0] rc;
    logic [N*AW-1:0] rad;
    logic [CW-1:0]   rt;
    int              mk, mi;

    base_addrs = 64'hF7E6_D5C4_B3A2_9180;
    //            act           crits {c7..c0}                                          tgt    wait pulse kind     idx
    vecs[0] = '{8'b0010_0100, {5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd7, 5'd3, 5'd3},       5'd3,  0,   1'b0, K_HIT,   5};
    vecs[1] = '{8'b0100_0010, {5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4},       5'd4,  1,   1'b0, K_HIT,   1};
    vecs[2] = '{8'b0000_0000, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0},       5'd0,  0,   1'b0, K_EMPTY, 0};
    vecs[3] = '{8'b0001_1000, {5'd3, 5'd3, 5'd3, 5'd10, 5'd9, 5'd3, 5'd3, 5'd3},      5'd3,  0,   1'b0, K_MISS,  0};
    vecs[4] = '{8'b1000_0001, {5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2},       5'd5,  5,   1'b1, K_HIT,   7};
    vecs[5] = '{8'b1111_1111, {5'd30, 5'd30, 5'd30, 5'd31, 5'd30, 5'd30, 5'd30, 5'd30}, 5'd31, 2, 1'b0, K_HIT,   4};
    vecs[6] = '{8'b1111_1111, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0},       5'd0,  0,   1'b0, K_HIT,   0};

    rst = 1'b1;
    ca_pronto_in = 1'b0;
    ca_criterio_geral_in = '0;
    na_ativo_in = '0;
    na_criterio_in = '0;
    na_endereco_in = '0;
    sa_liberar_in = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].act, vecs[i].crits, base_addrs, vecs[i].tgt,
             vecs[i].lib_wait, vecs[i].pulse_pronto, vecs[i].exp_kind, vecs[i].exp_idx);

    // Live node inputs: match moves from slot 6 to slot 3 while the scan runs
    na_ativo_in          = 8'b0100_0000;
    na_criterio_in       = {8{5'd3}};
    na_endereco_in       = base_addrs;
    ca_criterio_geral_in = 5'd3;
    ca_pronto_in         = 1'b1;
    step();
    ca_pronto_in = 1'b0;
    na_ativo_in  = 8'b0000_1000;
    for (int n = 0; n < 4; n++) step();
    chk("live.valido", 64'(sa_valido_o), 64'd1);
    chk("live.indice", 64'(sa_indice_o), 64'd3);
    sa_liberar_in = 1'b1;
    step();
    sa_liberar_in = 1'b0;
    chk("live.grant", 64'(sa_grant_o), 64'h08);
    step();
    step();

    // Reset mid-SCAN of a would-be miss: no late vazio pulse afterwards
    na_ativo_in    = 8'b0001_1000;
    na_criterio_in = vecs[3].crits;
    ca_criterio_geral_in = 5'd3;
    ca_pronto_in = 1'b1;
    step();
    ca_pronto_in = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all_zero("rst_scan");
    for (int n = 0; n < 10; n++) begin
      step();
      chk($sformatf("rst_scan.vazio_c%0d", n),   64'(sa_vazio_o),   64'd0);
      chk($sformatf("rst_scan.ocupado_c%0d", n), 64'(sa_ocupado_o), 64'd0);
    end

    // Reset in VALID together with release: the grant must be dropped
    na_ativo_in    = vecs[0].act;
    na_criterio_in = vecs[0].crits;
    ca_criterio_geral_in = 5'd3;
    ca_pronto_in = 1'b1;
    step();
    ca_pronto_in = 1'b0;
    for (int n = 0; n < 6; n++) step();
    chk("rst_valid.pre_valido", 64'(sa_valido_o), 64'd1);
    chk("rst_valid.pre_indice", 64'(sa_indice_o), 64'd5);
    rst = 1'b1;
    sa_liberar_in = 1'b1;
    step();
    rst = 1'b0;
    sa_liberar_in = 1'b0;
    chk_all_zero("rst_valid");
    step();
    chk("rst_valid.no_grant", 64'(sa_grant_o),  64'd0);
    chk("rst_valid.idle",     64'(sa_valido_o), 64'd0);
    step();

    // Randomized transactions against the reference model
    for (int r = 0; r < 40; r++) begin
      ra = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ra = '0;
      for (int s = 0; s < N; s++)
        rc[CW*s +: CW] = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      rt  = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      rad = {$urandom, $urandom};
      model(ra, rc, rt, mk, mi);
      do_txn($sformatf("rnd%0d", r), ra, rc, rad, rt, $urandom_range(0, 3),
             1'($urandom_range(0, 1)), mk, mi);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/selecionar_ativo.md
# selecionar_ativo

Consumer-side companion of the active-node minimum search: once the minimum search reports `ca_pronto` with the global minimum criterion, this block locates the active node holding that criterion. It presents the node's index and address to the downstream expander through a valid/release handshake, then issues a one-cycle one-hot grant back to the node array. If no active node holds the minimum, it reports an empty/miss condition instead.

## Interface
- `NUM_NA`, 8: number of active-node slots; must be ≥ 2.
- `ADDR_WIDTH`, 8: width of each node address.
- `CRITERIO_WIDTH`, 5: width of each node criterion.
- Local `COUNT_WIDTH` = `$clog2(NUM_NA)`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high; has priority over all other inputs.
- `ca_pronto_in` in 1: minimum search done; single-cycle pulse.
- `ca_criterio_geral_in` in `CRITERIO_WIDTH`: global minimum criterion; sampled when `ca_pronto_in`=1.
- `na_ativo_in` in `NUM_NA`: active flag per slot.
- `na_criterio_in` in `NUM_NA*CRITERIO_WIDTH`: packed criteria; slot i occupies bits `[CRITERIO_WIDTH*i +: CRITERIO_WIDTH]`.
- `na_endereco_in` in `NUM_NA*ADDR_WIDTH`: packed addresses, packed the same way.
- `sa_liberar_in` in 1: downstream ready/accept.
- `sa_valido_o` out 1: selection valid.
- `sa_indice_o` out `COUNT_WIDTH`: selected slot index.
- `sa_endereco_o` out `ADDR_WIDTH`: selected slot address.
- `sa_grant_o` out `NUM_NA`: one-hot grant pulse to the selected slot.
- `sa_vazio_o` out 1: one-cycle pulse, no matching active node.
- `sa_ocupado_o` out 1: high whenever the state is not IDLE.

## Operation
States and transitions:
- **IDLE**
  - On `ca_pronto_in`=1, latch `ca_criterio_geral_in` into `crit_r`.
  - If `na_ativo_in`==0 in that same cycle, pulse `sa_vazio_o` next cycle and stay in IDLE.
  - Otherwise, go to SCAN with `count`=0.
- **SCAN**: examine one slot per cycle at `count`.
  - Match is `na_ativo_in[count]` && `na_criterio[count]`==`crit_r`. On a match, register `count` into `sa_indice_o` and that slot's address into `sa_endereco_o`, then go to VALID.
  - No match and `count`==`NUM_NA-1`: pulse `sa_vazio_o`, go to IDLE. This covers the node set changing after the minimum search.
  - Otherwise, `count`+1.
- **VALID**
  - `sa_valido_o`=1; `sa_indice_o` and `sa_endereco_o` stay stable.
  - When `sa_liberar_in`=1, the handshake completes that cycle. Go to GRANT.
- **GRANT**: `sa_grant_o` = one-hot at `sa_indice_o` for exactly one cycle, `sa_valido_o`=0, then go to IDLE.

Rules:
- Ties resolve to the lowest index, because the scan order is ascending.
- `ca_pronto_in` is ignored outside IDLE. No queueing; a dropped pulse is the upstream's responsibility.
- `sa_indice_o` and `sa_endereco_o` hold their last values in IDLE. They are meaningful only while `sa_valido_o`=1.
- The criterion compare is unsigned equality at full `CRITERIO_WIDTH`. An all-ones criterion is a legal value, not a sentinel.
- Node inputs are not latched. SCAN reads them live each cycle.

## Timing
- Reset value of every output is 0; `count`=0, `crit_r`=0, state = IDLE. Reset is applied at the next edge, including mid-SCAN, in VALID, or in GRANT, and any pending grant is dropped.
- Write t = the cycle in which `ca_pronto_in` is sampled, and k = the first matching index.
  - SCAN occupies cycles t+1 … t+1+k.
  - `sa_valido_o` rises at t+2+k.
  - Best-case latency is 2 cycles (k=0); worst-case match latency is `NUM_NA`+1.
- A full miss pulses `sa_vazio_o` at t+1+`NUM_NA`.
- The immediate-empty case pulses `sa_vazio_o` at t+1.
- A handshake in cycle h produces the grant in h+1; `sa_ocupado_o` falls at h+2.
- `sa_liberar_in` asserted before `sa_valido_o` has no effect. `sa_valido_o` never drops without a handshake, except on reset.
- `sa_ocupado_o` is 1 from t+1 until the return to IDLE.

## Test plan
- **Single match.** Setup: `NUM_NA`=8, active=8'b0010_0100, criteria slot2=7 and slot5=3; pronto at t with criterio=3. Required: `sa_valido_o` at t+7, indice=5, endereco=slot5 address. With liberar high at t+7, grant=8'b0010_0000 at t+8.
- **Tie.** Setup: slots 1 and 6 both active with criterion 4; criterio=4. Required: indice=1, valido at t+3.
- **Empty.** Setup: pronto with `na_ativo_in`=0. Required: `sa_vazio_o`=1 at t+1 only, `sa_ocupado_o` stays 0.
- **Miss.** Setup: active slots hold criteria 9 and 10; criterio=3. Required: `sa_vazio_o` pulse at t+9, then back to IDLE.
- **Backpressure and ignored pronto.** Setup: hold liberar=0 for 5 cycles in VALID and pulse `ca_pronto_in` during it. Required: outputs stay stable, the pulse is ignored, and there is exactly one grant after liberar.
- **Reset mid-operation.** Setup: assert `rst` mid-SCAN, and separately in VALID. Required: all outputs 0 at the next edge, and no grant is emitted.
